// File: rtl/std_cache_pkg.sv
// ---------------------------------------------------------------------------
// std_cache_pkg: bypass request/response types and arbiter state. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package std_cache_pkg;

  localparam int unsigned ID_W   = 4;
  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [7:0]        be;
    logic [1:0]        size;
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bypass_req_t;

  typedef struct packed {
    logic              gnt;
    logic              valid;
    logic [DATA_W-1:0] rdata;
  } bypass_rsp_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    WAIT_RSP = 2'd2
  } arb_state_e;

  // Advance a port index by one, wrapping at the port count.
  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v,
                                               input int unsigned n);
    if ((32'(v) + 32'd1) >= n) return '0;
    return v + 4'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb_comb.sv
// ---------------------------------------------------------------------------
// rr_arb_comb: combinational round-robin picker, scans upward from ptr. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arb_comb #(
  parameter int unsigned NR_PORTS = 3
) (
  input  logic [NR_PORTS-1:0] req,
  input  logic [3:0]          ptr,
  output logic                valid,
  output logic [3:0]          idx
);

  int unsigned pos;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int unsigned i = 0; i < NR_PORTS; i++) begin
      pos = 32'(ptr) + i;
      if (pos >= NR_PORTS) pos = pos - NR_PORTS;
      for (int unsigned j = 0; j < NR_PORTS; j++) begin
        if (!valid && (pos == j) && req[j]) begin
          valid = 1'b1;
          idx   = 4'(j);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/std_bypass_arbiter.sv
// ---------------------------------------------------------------------------
// std_bypass_arbiter: shares the uncached bypass path, one transaction at a time. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module std_bypass_arbiter
  import std_cache_pkg::*;
#(
  parameter int unsigned NR_PORTS = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  bypass_req_t [NR_PORTS-1:0] req_i,
  output bypass_rsp_t [NR_PORTS-1:0] rsp_o,
  output bypass_req_t                req_o,
  input  bypass_rsp_t                rsp_i,
  output logic                       busy_o,
  output logic [3:0]                 owner_o,
  output logic                       spurious_o
);

  arb_state_e state_q, state_d;
  logic [3:0] owner_q, owner_d;
  logic [3:0] rr_q, rr_d;

  logic [NR_PORTS-1:0] req_vec;
  logic                arb_valid;
  logic [3:0]          arb_idx;

  logic [3:0]  cur;
  bypass_req_t cur_req;
  logic        fwd;
  logic        deliver;

  for (genvar g = 0; g < NR_PORTS; g++) begin : g_req_vec
    assign req_vec[g] = req_i[g].req;
  end

  rr_arb_comb #(
    .NR_PORTS(NR_PORTS)
  ) u_rr_arb (
    .req  (req_vec),
    .ptr  (rr_q),
    .valid(arb_valid),
    .idx  (arb_idx)
  );

  // Only IDLE arbitrates; HOLD and WAIT_RSP stay locked to the owner.
  assign cur = (state_q == IDLE) ? arb_idx : owner_q;

  always_comb begin
    cur_req = '0;
    for (int unsigned p = 0; p < NR_PORTS; p++) begin
      if (4'(p) == cur) cur_req = req_i[p];
    end
  end

  assign fwd     = (state_q == IDLE) ? arb_valid : ((state_q == HOLD) && cur_req.req);
  assign deliver = rsp_i.valid && ((fwd && rsp_i.gnt) || (state_q == WAIT_RSP));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    unique case (state_q)
      IDLE: begin
        if (fwd) begin
          if (rsp_i.gnt && rsp_i.valid) begin
            rr_d = wrap_inc(cur, NR_PORTS);
          end else if (rsp_i.gnt) begin
            state_d = WAIT_RSP;
            owner_d = cur;
          end else begin
            state_d = HOLD;
            owner_d = cur;
          end
        end
      end
      HOLD: begin
        // A requester withdrawing before its grant abandons the slot.
        if (!cur_req.req) begin
          state_d = IDLE;
          owner_d = '0;
        end else if (rsp_i.gnt && rsp_i.valid) begin
          state_d = IDLE;
          owner_d = '0;
          rr_d    = wrap_inc(owner_q, NR_PORTS);
        end else if (rsp_i.gnt) begin
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (rsp_i.valid) begin
          state_d = IDLE;
          owner_d = '0;
          rr_d    = wrap_inc(owner_q, NR_PORTS);
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = '0;
      end
    endcase
  end

  always_comb begin
    req_o = '0;
    rsp_o = '0;
    if (fwd) begin
      req_o    = cur_req;
      req_o.id = cur;
    end
    for (int unsigned p = 0; p < NR_PORTS; p++) begin
      if (4'(p) == cur) begin
        rsp_o[p].gnt = fwd && rsp_i.gnt;
        if (deliver) begin
          rsp_o[p].valid = 1'b1;
          rsp_o[p].rdata = rsp_i.rdata;
        end
      end
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign owner_o    = owner_q;
  assign spurious_o = rsp_i.valid && !deliver;

endmodule

`default_nettype wire

// File: tb/tb_std_bypass_arbiter.sv
// ---------------------------------------------------------------------------
// tb_std_bypass_arbiter: vector table, round-robin sequence and random model check. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_std_bypass_arbiter;
  import std_cache_pkg::*;

  localparam int N = 3;

  logic                clk = 1'b0;
  logic                rst_n;
  bypass_req_t [N-1:0] req_i;
  bypass_rsp_t [N-1:0] rsp_o;
  bypass_req_t         req_o;
  bypass_rsp_t         rsp_i;
  logic                busy;
  logic [3:0]          owner;
  logic                spur;

  int errors = 0;
  int checks = 0;

  bypass_req_t pl [N];

  std_bypass_arbiter #(.NR_PORTS(N)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .req_i     (req_i),
    .rsp_o     (rsp_o),
    .req_o     (req_o),
    .rsp_i     (rsp_i),
    .busy_o    (busy),
    .owner_o   (owner),
    .spurious_o(spur)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rstn;
    logic [2:0]  rq;
    logic        g;
    logic        v;
    logic [63:0] rd;
    logic        er;
    logic [3:0]  eid;
    logic [2:0]  eg;
    logic [2:0]  ev;
    logic        eb;
    logic [3:0]  eo;
    logic        es;
  } vec_t;

  function automatic vec_t V(logic rstn, logic [2:0] rq, logic g, logic v, logic [63:0] rd,
                             logic er, logic [3:0] eid, logic [2:0] eg, logic [2:0] ev,
                             logic eb, logic [3:0] eo, logic es);
    vec_t t;
    t.rstn = rstn; t.rq = rq; t.g = g; t.v = v; t.rd = rd;
    t.er = er; t.eid = eid; t.eg = eg; t.ev = ev; t.eb = eb; t.eo = eo; t.es = es;
    return t;
  endfunction

  function automatic bypass_req_t mk_req(int p);
    bypass_req_t r;
    r       = '0;
    r.req   = 1'b1;
    r.we    = 1'(p % 2);
    r.be    = 8'hFF;
    r.size  = 2'd3;
    r.id    = 4'hF;
    r.addr  = 64'h8000_0000 + 64'(p) * 64'h40;
    r.wdata = 64'hCAFE_0000_0000_0000 | 64'(p);
    return r;
  endfunction

  function automatic bypass_req_t fwd_of(int p);
    bypass_req_t r;
    r    = pl[p];
    r.id = 4'(p);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rstn, input logic [N-1:0] m, input logic g,
                       input logic v, input logic [63:0] rd);
    @(negedge clk);
    rst_n = rstn;
    for (int p = 0; p < N; p++) req_i[p] = m[p] ? pl[p] : '0;
    rsp_i.gnt   = g;
    rsp_i.valid = v;
    rsp_i.rdata = rd;
    #1;
  endtask

  vec_t tbl [25];
  int   exp_order [4];

  // Transaction-level reference: who holds the path, whether it was granted.
  int          m_owner;
  bit          m_granted;
  int          m_rr;
  logic [N-1:0] rq;

  initial begin
    rst_n = 1'b0;
    req_i = '0;
    rsp_i = '0;
    for (int p = 0; p < N; p++) pl[p] = mk_req(p);

    //            rstn rq     g     v     rdata                    er    id    gnt     val     busy  own   spur
    tbl[0]  = V(1'b0, 3'b000, 1'b0, 1'b0, 64'h0,                  1'b0, 4'd0, 3'b000, 3'b000, 1'b0, 4'd0, 1'b0);
    tbl[1]  = V(1'b0, 3'b000, 1'b0, 1'b0, 64'h0,                  1'b0, 4'd0, 3'b000, 3'b000, 1'b0, 4'd0, 1'b0);
    tbl[2]  = V(1'b1, 3'b000, 1'b0, 1'b0, 64'h0,                  1'b0, 4'd0, 3'b000, 3'b000, 1'b0, 4'd0, 1'b0);
    tbl[3]  = V(1'b1, 3'b010, 1'b1, 1'b0, 64'h0,                  1'b1, 4'd1, 3'b010, 3'b000, 1'b0, 4'd0, 1'b0);
    tbl[4]  = V(1'b1, 3'b000, 1'b0, 1'b0, 64'h0,                  1'b0, 4'd0, 3'b000, 3'b000, 1'b1, 4'd1, 1'b0);
    tbl[5]  = V(1'b1, 3'b000, 1'b0, 1'b0, 64'h0,                  1'b0, 4'd0, 3'b000, 3'b000, 1'b1, 4'd1, 1'b0);
    tbl[6]  = V(1'b1, 3'b000, 1'b0, 1'b1, 64'hDEAD_BEEF_0000_0001, 1'b0, 4'd0, 3'b000, 3'b010, 1'b1, 4'd1, 1'b0);
    tbl[7]  = V(1'b1, 3'b000, 1'b0, 1'b0, 64'h0,                  1'b0, 4'd0, 3'b000, 3'b000, 1'b0, 4'd0, 1'b0);
    tbl[8]  = V(1'b1, 3'b100, 1'b0, 1'b0, 64'h0,                  1'b1, 4'd2, 3'b000, 3'b000, 1'b0, 4'd0, 1'b0);
    tbl[9]  = V(1'b1, 3'b101, 1'b0, 1'b0, 64'h0,                  1'b1, 4'd2, 3'b000, 3'b000, 1'b1, 4'd2, 1'b0);
    tbl[10] = V(1'b1, 3'b101, 1'b0, 1'b0, 64'h0,                  1'b1, 4'd2, 3'b000, 3'b000, 1'b1, 4'd2, 1'b0);
    tbl[11] = V(1'b1, 3'b101, 1'b0, 1'b0, 64'h0,                  1'b1, 4'd2, 3'b000, 3'b000, 1'b1, 4'd2, 1'b0);
    tbl[12] = V(1'b1, 3'b101, 1'b1, 1'b0, 64'h0,                  1'b1, 4'd2, 3'b100, 3'b000, 1'b1, 4'd2, 1'b0);
    tbl[13] = V(1'b1, 3'b001, 1'b0, 1'b1, 64'h2222,               1'b0, 4'd0, 3'b000, 3'b100, 1'b1, 4'd2, 1'b0);
    tbl[14] = V(1'b1, 3'b001, 1'b1, 1'b1, 64'h3333,               1'b1, 4'd0, 3'b001, 3'b001, 1'b0, 4'd0, 1'b0);
    tbl[15] = V(1'b1, 3'b010, 1'b1, 1'b0, 64'h0,                  1'b1, 4'd1, 3'b010, 3'b000, 1'b0, 4'd0, 1'b0);
    tbl[16] = V(1'b1, 3'b000, 1'b0, 1'b0, 64'h0,                  1'b0, 4'd0, 3'b000, 3'b000, 1'b1, 4'd1, 1'b0);
    tbl[17] = V(1'b0, 3'b000, 1'b0, 1'b0, 64'h0,                  1'b0, 4'd0, 3'b000, 3'b000, 1'b1, 4'd1, 1'b0);
    tbl[18] = V(1'b1, 3'b000, 1'b0, 1'b1, 64'h4444,               1'b0, 4'd0, 3'b000, 3'b000, 1'b0, 4'd0, 1'b1);
    tbl[19] = V(1'b1, 3'b000, 1'b0, 1'b0, 64'h0,                  1'b0, 4'd0, 3'b000, 3'b000, 1'b0, 4'd0, 1'b0);
    tbl[20] = V(1'b1, 3'b000, 1'b0, 1'b1, 64'h5555,               1'b0, 4'd0, 3'b000, 3'b000, 1'b0, 4'd0, 1'b1);
    tbl[21] = V(1'b1, 3'b000, 1'b0, 1'b0, 64'h0,                  1'b0, 4'd0, 3'b000, 3'b000, 1'b0, 4'd0, 1'b0);
    tbl[22] = V(1'b1, 3'b010, 1'b0, 1'b0, 64'h0,                  1'b1, 4'd1, 3'b000, 3'b000, 1'b0, 4'd0, 1'b0);
    tbl[23] = V(1'b1, 3'b000, 1'b1, 1'b0, 64'h0,                  1'b0, 4'd0, 3'b000, 3'b000, 1'b1, 4'd1, 1'b0);
    tbl[24] = V(1'b1, 3'b000, 1'b0, 1'b0, 64'h0,                  1'b0, 4'd0, 3'b000, 3'b000, 1'b0, 4'd0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      logic [2:0]  gm;
      logic [2:0]  vm;
      logic [63:0] rdor;
      bypass_req_t er;
      drive(tbl[i].rstn, tbl[i].rq, tbl[i].g, tbl[i].v, tbl[i].rd);
      gm   = '0;
      vm   = '0;
      rdor = '0;
      for (int p = 0; p < N; p++) begin
        gm[p] = rsp_o[p].gnt;
        vm[p] = rsp_o[p].valid;
        rdor  = rdor | rsp_o[p].rdata;
      end
      er = tbl[i].er ? fwd_of(int'(tbl[i].eid)) : '0;
      chk($sformatf("v%0d.req_o", i), 160'(req_o), 160'(er));
      chk($sformatf("v%0d.gnt", i), 160'(gm), 160'(tbl[i].eg));
      chk($sformatf("v%0d.valid", i), 160'(vm), 160'(tbl[i].ev));
      chk($sformatf("v%0d.rdata", i), 160'(rdor), 160'((tbl[i].ev != 0) ? tbl[i].rd : 64'h0));
      chk($sformatf("v%0d.busy", i), 160'(busy), 160'(tbl[i].eb));
      chk($sformatf("v%0d.owner", i), 160'(owner), 160'(tbl[i].eo));
      chk($sformatf("v%0d.spur", i), 160'(spur), 160'(tbl[i].es));
    end

    // All three ports requesting continuously; response two cycles after grant.
    exp_order = '{0, 1, 2, 0};
    for (int t = 0; t < 4; t++) begin
      int gp;
      gp = -1;
      drive(1'b1, 3'b111, 1'b1, 1'b0, 64'h0);
      for (int p = 0; p < N; p++) if (rsp_o[p].gnt) gp = p;
      chk($sformatf("rr_order%0d", t), 160'(gp), 160'(exp_order[t]));
      drive(1'b1, 3'b111, 1'b0, 1'b0, 64'h0);
      drive(1'b1, 3'b111, 1'b0, 1'b1, 64'h7000 + 64'(t));
      chk($sformatf("rr_rdata%0d", t), 160'(rsp_o[exp_order[t]].rdata), 160'(64'h7000 + 64'(t)));
    end

    drive(1'b0, '0, 1'b0, 1'b0, 64'h0);
    drive(1'b0, '0, 1'b0, 1'b0, 64'h0);
    m_owner   = -1;
    m_granted = 1'b0;
    m_rr      = 0;
    rq        = '0;

    for (int cyc = 0; cyc < 600; cyc++) begin
      logic        rstn;
      logic        g;
      logic        v;
      logic [63:0] rd;
      int          sel;
      int          dlv;
      bypass_req_t exp_req;
      bypass_rsp_t exp_rsp;
      for (int p = 0; p < N; p++) begin
        if (!rq[p] && ($urandom_range(0, 2) == 0)) begin
          rq[p]       = 1'b1;
          pl[p].req   = 1'b1;
          pl[p].we    = 1'($urandom_range(0, 1));
          pl[p].be    = 8'($urandom);
          pl[p].size  = 2'($urandom);
          pl[p].id    = 4'($urandom);
          pl[p].addr  = {$urandom, $urandom};
          pl[p].wdata = {$urandom, $urandom};
        end
      end
      rstn = ($urandom_range(0, 99) != 0);
      g    = 1'($urandom_range(0, 1));
      v    = ($urandom_range(0, 3) == 0);
      rd   = {$urandom, $urandom};
      drive(rstn, rq, g, v, rd);

      sel = -1;
      dlv = -1;
      if (m_owner < 0) begin
        for (int i = 0; i < N; i++) begin
          int k;
          k = (m_rr + i) % N;
          if (sel < 0 && rq[k]) sel = k;
        end
      end else if (!m_granted && rq[m_owner]) begin
        sel = m_owner;
      end
      if (v) begin
        if (sel >= 0 && g) dlv = sel;
        else if (m_granted) dlv = m_owner;
      end
      exp_req = (sel >= 0) ? fwd_of(sel) : '0;

      chk("rnd.req_o", 160'(req_o), 160'(exp_req));
      for (int p = 0; p < N; p++) begin
        exp_rsp.gnt   = (p == sel) && g;
        exp_rsp.valid = (p == dlv);
        exp_rsp.rdata = (p == dlv) ? rd : 64'h0;
        chk($sformatf("rnd.rsp_o[%0d]", p), 160'(rsp_o[p]), 160'(exp_rsp));
      end
      chk("rnd.busy", 160'(busy), 160'(m_owner >= 0));
      chk("rnd.owner", 160'(owner), 160'((m_owner < 0) ? 0 : m_owner));
      chk("rnd.spur", 160'(spur), 160'(v && (dlv < 0)));

      if (sel >= 0 && g) rq[sel] = 1'b0;
      if (!rstn) begin
        m_owner   = -1;
        m_granted = 1'b0;
        m_rr      = 0;
      end else if (dlv >= 0) begin
        m_owner   = -1;
        m_granted = 1'b0;
        m_rr      = (dlv + 1) % N;
      end else if (sel >= 0) begin
        m_owner   = sel;
        m_granted = g;
      end else if (m_owner >= 0 && !m_granted) begin
        m_owner = -1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
